lii_out_rr_arbiter: RTL and testbench

- Shares one physical LII output channel (p0) between N logical kernel output streams.
- Round-robin arbitration with a per-grant burst limit. Each beat is stamped with a fixed source ID and a per-requester destination ID.
- Output is a one-stage registered slice.
- Sits between several HLS kernel wrappers' pack outputs and the LII phy output port of a reconfigurable region.

---
 rtl/lii_pkg.sv | 48 ++++
 rtl/lii_out_rr_arbiter_if.sv | 38 +++
 rtl/lii_reg_slice.sv | 40 ++++
 rtl/lii_out_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_lii_out_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lii_pkg
// Description : Shared LII types, widths and the round-robin pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lii_pkg;

    localparam int LII_ID_W    = 8;
    localparam int BURST_CNT_W = 8;
    localparam int MAX_REQ     = 8;
    localparam int REQ_IDX_W   = 3;

    typedef logic [LII_ID_W-1:0] lii_id_t;

    typedef struct packed {
        logic                 found;
        logic [REQ_IDX_W-1:0] idx;
        logic [MAX_REQ-1:0]   onehot;
    } rr_pick_t;

    // First set request at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [REQ_IDX_W-1:0] ptr,
                                         input int                   n);
        rr_pick_t             r;
        int                   j;
        logic [REQ_IDX_W-1:0] sel;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (!r.found && (k < n)) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                sel = REQ_IDX_W'(j);
                if (req[sel]) begin
                    r.found       = 1'b1;
                    r.idx         = sel;
                    r.onehot[sel] = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lii_out_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : lii_out_rr_arbiter_if
// Description : Requester streams plus the shared LII p0 output channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface lii_out_rr_arbiter_if
    import lii_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 64
);
    logic [N*PW-1:0]       s_tdata;
    logic [N-1:0]          s_tvalid;
    logic [N-1:0]          s_tready;
    logic [N*LII_ID_W-1:0] s_dst;
    logic [PW-1:0]         lii_out_p0_tdata;
    logic                  lii_out_p0_tvalid;
    logic                  lii_out_p0_tready;
    lii_id_t               lii_out_p0_src;
    lii_id_t               lii_out_p0_dst;
    logic [N-1:0]          grant;

    // Environment side: kernels and the downstream phy.
    modport master (
        output s_tdata, s_tvalid, s_dst, lii_out_p0_tready,
        input  s_tready, lii_out_p0_tdata, lii_out_p0_tvalid,
        input  lii_out_p0_src, lii_out_p0_dst, grant
    );

    // Arbiter side.
    modport slave (
        input  s_tdata, s_tvalid, s_dst, lii_out_p0_tready,
        output s_tready, lii_out_p0_tdata, lii_out_p0_tvalid,
        output lii_out_p0_src, lii_out_p0_dst, grant
    );
endinterface
`default_nettype wire

// File: rtl/lii_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : lii_reg_slice
// Description : One-stage valid/ready register slice; holds data under
//               backpressure and accepts a new beat whenever the slot drains.
// Revision    : 1.0 - initial release
// ============================================================================
module lii_reg_slice #(
    parameter int W = 72
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         i_valid,
    output logic              o_ready,
    input  wire logic [W-1:0] i_data,
    output logic              o_valid,
    output logic [W-1:0]      o_data,
    input  wire logic         i_ready
);
    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Load on accept, drain on downstream ready, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/lii_out_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lii_out_rr_arbiter
// Description : Round-robin arbiter sharing LII output p0 among N streams,
//               with a per-grant burst limit and a registered output slice.
// Revision    : 1.0 - initial release
// ============================================================================
module lii_out_rr_arbiter
    import lii_pkg::*;
#(
    parameter int      N      = 4,
    parameter int      PW     = 64,
    parameter int      BURST  = 16,
    parameter lii_id_t SRC_ID = 8'h00
) (
    input  wire logic             aclk,
    input  wire logic             arstn,
    lii_out_rr_arbiter_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [BURST_CNT_W-1:0] c_burst_last = BURST_CNT_W'(BURST - 1);
    localparam logic [REQ_IDX_W-1:0]   c_last_idx   = REQ_IDX_W'(N - 1);

    state_t                  r_state,     w_state_nxt;
    logic [N-1:0]            r_grant,     w_grant_nxt;
    logic [REQ_IDX_W-1:0]    r_gidx,      w_gidx_nxt;
    logic [REQ_IDX_W-1:0]    r_rr_ptr,    w_rr_ptr_nxt;
    logic [BURST_CNT_W-1:0]  r_burst_cnt, w_burst_nxt;

    rr_pick_t                w_pick;
    logic                    w_pick_unused;
    logic                    w_gvalid;
    logic                    w_slot_free;
    logic                    w_accept;
    logic [PW-1:0]           w_sel_data;
    lii_id_t                 w_sel_dst;
    logic                    w_out_valid;
    logic [PW-1:0]           w_out_data;
    lii_id_t                 w_out_dst;

    assign w_pick        = rr_pick(MAX_REQ'(bus.s_tvalid), r_rr_ptr, N);
    assign w_pick_unused = ^w_pick.onehot;
    assign w_gvalid      = |(bus.s_tvalid & r_grant);
    assign w_accept      = (r_state == ST_GRANT) && w_gvalid && w_slot_free;

    // Route the granted stream's data and destination to the output slice.
    always_comb begin
        w_sel_data = '0;
        w_sel_dst  = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_sel_data = bus.s_tdata[i*PW +: PW];
                w_sel_dst  = bus.s_dst[i*LII_ID_W +: LII_ID_W];
            end
        end
    end

    // Next-state: pick a winner in IDLE, count beats and release in GRANT.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_rr_ptr_nxt = r_rr_ptr;
        w_burst_nxt  = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick.found) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_pick.onehot[N-1:0];
                    w_gidx_nxt  = w_pick.idx;
                    w_burst_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (w_accept) begin
                    w_burst_nxt = r_burst_cnt + 8'd1;
                end
                // Budget spent or requester gone; a blocked slot never releases.
                if ((w_accept && (r_burst_cnt == c_burst_last)) || !w_gvalid) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_burst_nxt  = '0;
                    w_rr_ptr_nxt = (r_gidx == c_last_idx) ? '0 : r_gidx + 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_gidx      <= w_gidx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    lii_reg_slice #(
        .W (PW + LII_ID_W)
    ) u_slice (
        .clk     (aclk),
        .rst_n   (arstn),
        .i_valid (w_accept),
        .o_ready (w_slot_free),
        .i_data  ({w_sel_dst, w_sel_data}),
        .o_valid (w_out_valid),
        .o_data  ({w_out_dst, w_out_data}),
        .i_ready (bus.lii_out_p0_tready)
    );

    assign bus.s_tready          = ((r_state == ST_GRANT) && w_slot_free) ? r_grant : '0;
    assign bus.grant             = r_grant;
    assign bus.lii_out_p0_tvalid = w_out_valid;
    assign bus.lii_out_p0_tdata  = w_out_data;
    assign bus.lii_out_p0_dst    = w_out_dst;
    assign bus.lii_out_p0_src    = w_out_valid ? SRC_ID : '0;
endmodule
`default_nettype wire

// File: tb/tb_lii_out_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lii_out_rr_arbiter
// Description : Directed bench for lii_out_rr_arbiter (N=4, BURST=4) with a
//               transaction-level reference model and literal pin checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lii_out_rr_arbiter;
    localparam int      N      = 4;
    localparam int      PW     = 64;
    localparam int      BURST  = 4;
    localparam logic [7:0] SRC = 8'h5A;

    logic clk;
    logic arstn;
    int   total = 0;
    int   bad   = 0;

    lii_out_rr_arbiter_if #(.N(N), .PW(PW)) bus ();

    lii_out_rr_arbiter #(
        .N(N), .PW(PW), .BURST(BURST), .SRC_ID(SRC)
    ) dut (
        .aclk  (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side stimulus controls.
    logic       b_arstn;
    logic [3:0] b_mask;
    logic       b_tready;
    int         b_lim [N];
    int         cnt   [N];
    logic [3:0] hs_prev;

    logic [63:0] log_data [$];
    logic [7:0]  log_dst  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the channel, beats used, search start, out slot.
    int          m_owner;
    int          m_used;
    int          m_ptr;
    logic        m_ov;
    logic [63:0] m_od;
    logic [7:0]  m_odst;

    always @(negedge clk) begin : p_cmp
        logic [3:0] eg;
        logic [3:0] es;
        logic       free;
        logic       acc;
        int         g;
        if (!arstn) begin
            m_owner = -1; m_used = 0; m_ptr = 0;
            m_ov = 1'b0; m_od = '0; m_odst = '0;
        end
        eg   = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        free = !m_ov || bus.lii_out_p0_tready;
        es   = (m_owner >= 0 && free) ? eg : 4'b0;
        chk("grant",    64'(bus.grant),             64'(eg));
        chk("s_tready", 64'(bus.s_tready),          64'(es));
        chk("tvalid",   64'(bus.lii_out_p0_tvalid), 64'(m_ov));
        chk("tdata",    bus.lii_out_p0_tdata,       m_od);
        chk("dst",      64'(bus.lii_out_p0_dst),    64'(m_odst));
        chk("src",      64'(bus.lii_out_p0_src),    64'(m_ov ? SRC : 8'h00));
        if (arstn) begin
            if (bus.lii_out_p0_tvalid && bus.lii_out_p0_tready) begin
                log_data.push_back(bus.lii_out_p0_tdata);
                log_dst.push_back(bus.lii_out_p0_dst);
            end
            if (m_owner < 0) begin
                if (bus.lii_out_p0_tready) m_ov = 1'b0;
                for (int k = 0; k < N; k++) begin
                    g = (m_ptr + k) % N;
                    if (m_owner < 0 && bus.s_tvalid[g]) begin
                        m_owner = g;
                        m_used  = 0;
                    end
                end
            end else begin
                g   = m_owner;
                acc = bus.s_tvalid[g] && free;
                if (acc) begin
                    m_ov   = 1'b1;
                    m_od   = bus.s_tdata[g*PW +: PW];
                    m_odst = bus.s_dst[g*8 +: 8];
                    m_used = m_used + 1;
                end else if (bus.lii_out_p0_tready) begin
                    m_ov = 1'b0;
                end
                if ((acc && m_used == BURST) || !bus.s_tvalid[g]) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % N;
                end
            end
        end
    end

    // One clock: drive just after the rising edge, return at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!b_arstn) cnt[i] = 0;
            else          cnt[i] = cnt[i] + int'(hs_prev[i]);
        end
        arstn = b_arstn;
        for (int i = 0; i < N; i++) begin
            bus.s_tvalid[i]        = b_mask[i] && (cnt[i] < b_lim[i]);
            bus.s_tdata[i*PW +: PW] = (64'(i) << 32) | 64'(cnt[i]);
            bus.s_dst[i*8 +: 8]    = 8'(8'h20 + i);
        end
        bus.lii_out_p0_tready = b_tready;
        if (!arstn) begin
            #1;
            chk("rst_tvalid", 64'(bus.lii_out_p0_tvalid), 64'd0);
            chk("rst_grant",  64'(bus.grant),             64'd0);
            chk("rst_sready", 64'(bus.s_tready),          64'd0);
        end
        @(negedge clk);
        hs_prev = bus.s_tvalid & bus.s_tready;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        b_arstn  = 1'b0;
        b_mask   = 4'b0;
        b_tready = 1'b1;
        for (int i = 0; i < N; i++) b_lim[i] = 1000;
        steps(2);
        log_data.delete();
        log_dst.delete();
        b_arstn = 1'b1;
    endtask

    task automatic chk_log(input int j, input logic [63:0] ed, input logic [7:0] edst);
        chk($sformatf("log%0d_data", j), (j < log_data.size()) ? log_data[j] : 64'hDEAD, ed);
        chk($sformatf("log%0d_dst", j),  (j < log_dst.size()) ? 64'(log_dst[j]) : 64'hDEAD, 64'(edst));
    endtask

    initial begin
        arstn = 1'b0;
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_dst    = '0;
        bus.lii_out_p0_tready = 1'b0;
        hs_prev = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;

        // Single requester: stream 1, bubble between bursts, data in order.
        do_reset();
        b_mask = 4'b0010;
        step();                                   // step0: release
        chk("t1_idle0", 64'(bus.grant), 64'd0);
        step();                                   // step1
        chk("t1_grant1", 64'(bus.grant), 64'b0010);
        steps(4);                                 // step5: bubble
        chk("t1_bubble", 64'(bus.grant), 64'd0);
        step();                                   // step6: regrant
        chk("t1_regrant", 64'(bus.grant), 64'b0010);
        steps(8);
        for (int j = 0; j < 8; j++) chk_log(j, (64'd1 << 32) | 64'(j), 8'h21);

        // All four requesters: four beats each, rotating 0,1,2,3.
        do_reset();
        b_mask = 4'b1111;
        steps(2);                                 // step1
        chk("t2_g0", 64'(bus.grant), 64'b0001);
        steps(5);                                 // step6
        chk("t2_g1", 64'(bus.grant), 64'b0010);
        steps(5);                                 // step11
        chk("t2_g2", 64'(bus.grant), 64'b0100);
        steps(10);
        for (int j = 0; j < 16; j++) chk_log(j, (64'(j / 4) << 32) | 64'(j % 4), 8'(8'h20 + j / 4));

        // Backpressure after the first beat: hold, then finish the burst.
        do_reset();
        b_mask = 4'b0001;
        steps(2);                                 // step1
        b_tready = 1'b0;
        steps(3);                                 // step4: stalled
        chk("t3_hold_v",  64'(bus.lii_out_p0_tvalid), 64'd1);
        chk("t3_hold_d",  bus.lii_out_p0_tdata,       64'd0);
        chk("t3_hold_ds", 64'(bus.lii_out_p0_dst),    64'h20);
        chk("t3_hold_sr", 64'(bus.s_tready),          64'd0);
        steps(2);                                 // step6
        b_tready = 1'b1;
        step();                                   // step7
        chk("t3_resume_sr", 64'(bus.s_tready), 64'b0001);
        steps(3);                                 // step10: budget spent
        chk("t3_release", 64'(bus.grant), 64'd0);
        steps(3);
        for (int j = 0; j < 5; j++) chk_log(j, 64'(j), 8'h20);

        // Mid-burst drop of stream 2, then wrap-around from pointer 3.
        do_reset();
        b_mask   = 4'b1100;
        b_lim[2] = 3;
        steps(2);                                 // step1
        chk("t4_g2", 64'(bus.grant), 64'b0100);
        steps(3);                                 // step4
        chk("t4_g2_hold", 64'(bus.grant), 64'b0100);
        b_mask = 4'b1001;
        step();                                   // step5: idle
        chk("t4_idle", 64'(bus.grant), 64'd0);
        step();                                   // step6
        chk("t4_g3", 64'(bus.grant), 64'b1000);
        steps(4);                                 // step10
        chk("t5_idle", 64'(bus.grant), 64'd0);
        step();                                   // step11
        chk("t5_g0", 64'(bus.grant), 64'b0001);
        step();
        for (int j = 0; j < 3; j++) chk_log(j, (64'd2 << 32) | 64'(j), 8'h22);
        for (int j = 0; j < 4; j++) chk_log(3 + j, (64'd3 << 32) | 64'(j), 8'h23);

        // Async reset mid-burst, then restart from pointer 0.
        do_reset();
        b_mask = 4'b0011;
        steps(3);                                 // step2
        b_arstn = 1'b0;
        steps(2);                                 // step3,4 in reset
        b_arstn = 1'b1;
        step();                                   // step5: release
        chk("t6_idle", 64'(bus.grant), 64'd0);
        step();                                   // step6
        chk("t6_g0", 64'(bus.grant), 64'b0001);
        step();                                   // step7
        chk("t6_v",  64'(bus.lii_out_p0_tvalid), 64'd1);
        chk("t6_d",  bus.lii_out_p0_tdata,       64'd0);
        chk("t6_ds", 64'(bus.lii_out_p0_dst),    64'h20);
        steps(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
